// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage operand issue block: ALU op codes,
// R-type funct values and instruction-class encodings.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_OR    = 2'b11
    } alu_class_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction-class / funct decode into a 4-bit ALU op code.
// Unsupported R-type funct values fall back to add and raise illegal_o.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] id_class_i,
    input  logic [5:0] id_funct_i,
    output logic [3:0] op_o,
    output logic       illegal_o
);

    always_comb begin
        op_o      = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_class_e'(id_class_i))
            CLS_ADD: op_o = ALU_ADD;
            CLS_SUB: op_o = ALU_SUB;
            CLS_OR:  op_o = ALU_OR;
            CLS_RTYPE: begin
                case (id_funct_i)
                    FN_ADD, FN_ADDU: op_o = ALU_ADD;
                    FN_SUB, FN_SUBU: op_o = ALU_SUB;
                    FN_AND:          op_o = ALU_AND;
                    FN_OR:           op_o = ALU_OR;
                    FN_SLT:          op_o = ALU_SLT;
                    default:         illegal_o = 1'b1;
                endcase
            end
            default: op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_operand_issue.sv
// ID/EX register feeding the EX-stage ALU, with load-use hazard detection.
// Define ALU_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [1:0]    id_class,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_mem_read,
    input  logic          id_reg_write,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dest,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          stall_in,
    input  logic          flush_in,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_dest,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_valid,
    output logic          ex_mem_read,
    output logic          ex_reg_write,
    output logic [RW-1:0] ex_dest,
    output logic          ex_illegal,
    output logic          stall_out
);

    logic [3:0]    dec_op;
    logic          dec_illegal;

    logic          valid_q, mem_read_q, reg_write_q, alu_src_q, illegal_q;
    logic [3:0]    op_q;
    logic [RW-1:0] dest_q, rs_q, rt_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [DW-1:0] rs_fwd, rt_fwd;
    logic          load_use;

    alu_op_decode u_dec (
        .id_class_i (id_class),
        .id_funct_i (id_funct),
        .op_o       (dec_op),
        .illegal_o  (dec_illegal)
    );

    assign load_use = id_valid & valid_q & mem_read_q & (dest_q != '0) &
                      ((dest_q == id_rs) | ((dest_q == id_rt) & ~id_alu_src));

`ifdef ALU_FWD_EN
    logic rs_exm_hit, rs_wb_hit, rt_exm_hit, rt_wb_hit;

    // r0 is hard-wired zero, so a tap writing r0 must never override it
    assign rs_exm_hit = exm_reg_write & (exm_dest != '0) & (exm_dest == rs_q);
    assign rs_wb_hit  = wb_reg_write  & (wb_dest  != '0) & (wb_dest  == rs_q);
    assign rt_exm_hit = exm_reg_write & (exm_dest != '0) & (exm_dest == rt_q);
    assign rt_wb_hit  = wb_reg_write  & (wb_dest  != '0) & (wb_dest  == rt_q);

    assign rs_fwd = rs_exm_hit ? exm_result : (rs_wb_hit ? wb_result : rs_data_q);
    assign rt_fwd = rt_exm_hit ? exm_result : (rt_wb_hit ? wb_result : rt_data_q);

    assign stall_out = load_use;
`else
    logic raw_hit;
    logic unused_fwd_taps;

    assign unused_fwd_taps = ^{exm_result, wb_result, rs_q, rt_q};

    // Without forwarding, any pending writeback to an ID source must drain first
    assign raw_hit = id_valid &
        ((exm_reg_write & (exm_dest != '0) & ((exm_dest == id_rs) | (exm_dest == id_rt))) |
         (wb_reg_write  & (wb_dest  != '0) & ((wb_dest  == id_rs) | (wb_dest  == id_rt))));

    assign rs_fwd    = rs_data_q;
    assign rt_fwd    = rt_data_q;
    assign stall_out = load_use | raw_hit;
`endif

    always_ff @(posedge clk) begin
        if (reset || flush_in || (!stall_in && stall_out)) begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= ALU_ADD;
            dest_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
        end else if (!stall_in) begin
            valid_q     <= id_valid;
            mem_read_q  <= id_mem_read;
            reg_write_q <= id_reg_write;
            alu_src_q   <= id_alu_src;
            illegal_q   <= dec_illegal;
            op_q        <= dec_op;
            dest_q      <= id_dest;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
        end
    end

    assign alu_a         = rs_fwd;
    assign alu_b         = alu_src_q ? imm_q : rt_fwd;
    assign alu_op        = op_q;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = valid_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_dest       = dest_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: an instruction-level model of the
// EX slot is compared every cycle, plus directed literal expectations.
module tb_alu_operand_issue;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, id_valid, id_alu_src, id_mem_read, id_reg_write;
    logic [1:0]    id_class;
    logic [5:0]    id_funct;
    logic [RW-1:0] id_rs, id_rt, id_dest;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          stall_in, flush_in;
    logic          exm_reg_write, wb_reg_write;
    logic [RW-1:0] exm_dest, wb_dest;
    logic [DW-1:0] exm_result, wb_result;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]    alu_op;
    logic          ex_valid, ex_mem_read, ex_reg_write, ex_illegal, stall_out;
    logic [RW-1:0] ex_dest;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_operand_issue #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_class(id_class),
        .id_funct(id_funct), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .stall_in(stall_in), .flush_in(flush_in),
        .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .ex_illegal(ex_illegal), .stall_out(stall_out)
    );

    // Model of the instruction sitting in EX
    typedef struct packed {
        logic          v, mr, rw, src, ill;
        logic [3:0]    op;
        logic [RW-1:0] dest, rs, rt;
        logic [DW-1:0] rsd, rtd, imm;
    } ent_t;

    ent_t m;

    function automatic ent_t bubble();
        ent_t e;
        e    = '0;
        e.op = 4'b0010;
        return e;
    endfunction

    // {illegal, op} from the class/funct rules
    function automatic logic [4:0] m_decode(input logic [1:0] c, input logic [5:0] f);
        if (c == 2'b00) return {1'b0, 4'b0010};
        if (c == 2'b01) return {1'b0, 4'b0110};
        if (c == 2'b11) return {1'b0, 4'b0001};
        if (f == 6'b100000 || f == 6'b100001) return {1'b0, 4'b0010};
        if (f == 6'b100010 || f == 6'b100011) return {1'b0, 4'b0110};
        if (f == 6'b100100) return {1'b0, 4'b0000};
        if (f == 6'b100101) return {1'b0, 4'b0001};
        if (f == 6'b101010) return {1'b0, 4'b0111};
        return {1'b1, 4'b0010};
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [RW-1:0] r, input logic [DW-1:0] d);
`ifdef ALU_FWD_EN
        if (r != 0 && exm_reg_write && exm_dest == r) return exm_result;
        if (r != 0 && wb_reg_write && wb_dest == r) return wb_result;
`endif
        return d;
    endfunction

    function automatic logic m_stall();
        logic lu, raw;
        lu  = id_valid && m.v && m.mr && m.dest != 0 &&
              (m.dest == id_rs || (m.dest == id_rt && !id_alu_src));
        raw = 1'b0;
`ifndef ALU_FWD_EN
        if (id_valid && exm_reg_write && exm_dest != 0 && (exm_dest == id_rs || exm_dest == id_rt))
            raw = 1'b1;
        if (id_valid && wb_reg_write && wb_dest != 0 && (wb_dest == id_rs || wb_dest == id_rt))
            raw = 1'b1;
`endif
        return lu || raw;
    endfunction

    always @(posedge clk) begin
        logic [4:0] d;
        if (reset || flush_in) m = bubble();
        else if (stall_in) m = m;
        else if (m_stall()) m = bubble();
        else begin
            d     = m_decode(id_class, id_funct);
            m.v   = id_valid;   m.mr  = id_mem_read; m.rw = id_reg_write;
            m.src = id_alu_src; m.ill = d[4];        m.op = d[3:0];
            m.dest = id_dest;   m.rs  = id_rs;       m.rt = id_rt;
            m.rsd = id_rs_data; m.rtd = id_rt_data;  m.imm = id_imm;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] frt;
        if (chk_en) begin
            frt = m_fwd(m.rt, m.rtd);
            chk("m_alu_a",   alu_a, m_fwd(m.rs, m.rsd));
            chk("m_alu_b",   alu_b, m.src ? m.imm : frt);
            chk("m_store",   ex_store_data, frt);
            chk("m_alu_op",  {28'd0, alu_op}, {28'd0, m.op});
            chk("m_ctrl",    {27'd0, ex_valid, ex_mem_read, ex_reg_write, ex_illegal, stall_out},
                             {27'd0, m.v, m.mr, m.rw, m.ill, m_stall()});
            chk("m_dest",    {27'd0, ex_dest}, {27'd0, m.dest});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [1:0] c, input logic [5:0] f,
                          input logic src, input logic mr, input logic rw,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] dst,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm);
        id_valid = v;   id_class = c;   id_funct = f;   id_alu_src = src;
        id_mem_read = mr; id_reg_write = rw;
        id_rs = rs; id_rt = rt; id_dest = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic set_taps(input logic ew, input logic [RW-1:0] ed, input logic [DW-1:0] er,
                            input logic ww, input logic [RW-1:0] wd, input logic [DW-1:0] wr);
        exm_reg_write = ew; exm_dest = ed; exm_result = er;
        wb_reg_write  = ww; wb_dest  = wd; wb_result  = wr;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_taps(0, 0, 0, 0, 0, 0);
        m = bubble();
        step();
        step();
        chk_en = 1'b1;
        chk("rst_op",    {28'd0, alu_op}, 32'h2);
        chk("rst_a",     alu_a, 32'h0);
        chk("rst_b",     alu_b, 32'h0);
        chk("rst_valid", {31'd0, ex_valid}, 32'h0);
        chk("rst_stall", {31'd0, stall_out}, 32'h0);
        reset = 1'b0;

        // R-type slt, then an unsupported funct
        set_id(1, 2'b10, 6'b101010, 0, 0, 1, 8, 9, 10, 32'h1234, 32'h5678, 0);
        step();
        chk("slt_op",  {28'd0, alu_op}, 32'h7);
        chk("slt_a",   alu_a, 32'h1234);
        chk("slt_b",   alu_b, 32'h5678);
        chk("slt_ill", {31'd0, ex_illegal}, 32'h0);
        set_id(1, 2'b10, 6'b000111, 0, 0, 1, 8, 9, 10, 32'h1, 32'h2, 0);
        step();
        chk("ill_op",  {28'd0, alu_op}, 32'h2);
        chk("ill_flag", {31'd0, ex_illegal}, 32'h1);

`ifdef ALU_FWD_EN
        set_id(1, 2'b10, 6'b100000, 0, 0, 1, 8, 9, 10, 32'hAAAA, 32'hBBBB, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_taps(1, 8, 32'h11, 1, 8, 32'h22);
        #1 chk("fwd_exm_prio", alu_a, 32'h11);
        set_taps(0, 8, 32'h11, 1, 8, 32'h22);
        #1 chk("fwd_wb", alu_a, 32'h22);
        set_taps(1, 0, 32'h11, 1, 0, 32'h22);
        #1 chk("fwd_r0_ignored", alu_a, 32'hAAAA);
        set_taps(0, 0, 0, 1, 9, 32'h33);
        #1 chk("fwd_rt_b", alu_b, 32'h33);
        chk("fwd_rt_store", ex_store_data, 32'h33);
        set_taps(0, 0, 0, 0, 0, 0);
`else
        set_id(1, 2'b10, 6'b100000, 0, 0, 1, 8, 9, 10, 32'hAAAA, 32'hBBBB, 0);
        set_taps(1, 8, 32'h11, 0, 0, 0);
        #1 chk("raw_exm_stall", {31'd0, stall_out}, 32'h1);
        set_taps(0, 0, 0, 1, 9, 32'h5);
        #1 chk("raw_wb_stall", {31'd0, stall_out}, 32'h1);
        set_taps(1, 0, 32'h1, 1, 0, 32'h2);
        #1 chk("raw_r0_nostall", {31'd0, stall_out}, 32'h0);
        set_taps(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        step();

        // Load-use: lw r5 in EX, add reads r5
        set_id(1, 2'b00, 0, 1, 1, 1, 1, 5, 5, 32'h100, 0, 32'h4);
        step();
        chk("lw_memrd", {31'd0, ex_mem_read}, 32'h1);
        chk("lw_b_imm", alu_b, 32'h4);
        set_id(1, 2'b10, 6'b100000, 0, 0, 1, 5, 6, 7, 32'h50, 32'h60, 0);
        #1 chk("lu_stall", {31'd0, stall_out}, 32'h1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'h0);
        chk("lu_bubble_op", {28'd0, alu_op}, 32'h2);
        chk("lu_stall_drop", {31'd0, stall_out}, 32'h0);
        step();
        chk("lu_issue_valid", {31'd0, ex_valid}, 32'h1);
        chk("lu_issue_a", alu_a, 32'h50);
        chk("lu_issue_dest", {27'd0, ex_dest}, 32'h7);

        // Flush beats stall
        set_id(1, 2'b01, 0, 0, 0, 1, 3, 4, 2, 32'h30, 32'h40, 0);
        step();
        flush_in = 1'b1; stall_in = 1'b1;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'h0);
        chk("flush_a", alu_a, 32'h0);
        chk("flush_op", {28'd0, alu_op}, 32'h2);
        flush_in = 1'b0; stall_in = 1'b0;

        // Hold for 3 cycles
        step();
        stall_in = 1'b1;
        set_id(1, 2'b11, 0, 1, 0, 1, 6, 7, 8, 32'h66, 32'h77, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_op", {28'd0, alu_op}, 32'h6);
            chk("hold_a", alu_a, 32'h30);
            chk("hold_b", alu_b, 32'h40);
        end
        stall_in = 1'b0;

        // Hold and hazard together: lw stays in EX, hazard persists
        set_id(1, 2'b00, 0, 1, 1, 1, 1, 5, 5, 32'h200, 0, 32'h8);
        step();
        set_id(1, 2'b10, 6'b100010, 0, 0, 1, 2, 5, 9, 32'h21, 32'h22, 0);
        stall_in = 1'b1;
        step();
        chk("hs_stall", {31'd0, stall_out}, 32'h1);
        chk("hs_memrd", {31'd0, ex_mem_read}, 32'h1);
        stall_in = 1'b0;
        step();
        chk("hs_bubble", {31'd0, ex_valid}, 32'h0);
        step();
        chk("hs_issue_op", {28'd0, alu_op}, 32'h6);

        // Reset mid-stream
        reset = 1'b1;
        step();
        chk("rst2_valid", {31'd0, ex_valid}, 32'h0);
        chk("rst2_stall", {31'd0, stall_out}, 32'h0);
        reset = 1'b0;

        // Mixed traffic on a small register set so taps and hazards collide
        for (int i = 0; i < 60; i++) begin
            set_id($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? 6'b100000 + 6'($urandom_range(0, 10)) : 6'($urandom_range(0, 63)),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom);
            set_taps($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
                     $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
            stall_in = ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
            step();
        end
        stall_in = 1'b0; flush_in = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
